// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush sequencer for a 5-stage in-order pipeline: arbitrates memory wait,
// EX redirect and load-use hazards into one consistent set of stage enables.
module pipeline_stall_ctrl #(
  parameter int CNT_W  = 16,
  parameter int TO_W   = 8,
  parameter int MEM_TO = 200
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_hazard,
  input  logic             redirect,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             exmem_we,
  output logic             memwb_bubble,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    START    = 2'd0,
    RUN      = 2'd1,
    MEM_WAIT = 2'd2,
    ERROR    = 2'd3
  } state_t;

  localparam logic [TO_W:0]    TO_LIM  = (TO_W+1)'(MEM_TO);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t          state;
  state_t          state_nxt;
  logic [TO_W-1:0] wait_cnt;
  logic [TO_W-1:0] wait_nxt;
  logic [TO_W:0]   wait_inc;
  logic            flush_evt;
  logic            freeze;

  assign wait_inc = {1'b0, wait_cnt} + {{TO_W{1'b0}}, 1'b1};

  // Next-state and control decode; memory freeze outranks redirect, which outranks load-use
  always_comb begin
    pc_we        = 1'b0;
    ifid_we      = 1'b0;
    ifid_flush   = 1'b0;
    idex_bubble  = 1'b0;
    exmem_we     = 1'b0;
    memwb_bubble = 1'b0;
    flush_evt    = 1'b0;
    state_nxt    = state;
    wait_nxt     = wait_cnt;
    freeze       = 1'b0;
    case (state)
      START: begin
        ifid_flush   = 1'b1;
        idex_bubble  = 1'b1;
        memwb_bubble = 1'b1;
        state_nxt    = RUN;
        wait_nxt     = {TO_W{1'b0}};
      end
      RUN, MEM_WAIT: begin
        if (state == RUN) begin
          freeze = mem_req & ~mem_ready;
        end else begin
          freeze = ~mem_ready;
        end
        if (freeze) begin
          memwb_bubble = 1'b1;
          if (state == RUN) begin
            state_nxt = MEM_WAIT;
            wait_nxt  = {{(TO_W-1){1'b0}}, 1'b1};
          end else if (wait_inc >= TO_LIM) begin
            state_nxt = ERROR;
            wait_nxt  = wait_inc[TO_W-1:0];
          end else begin
            state_nxt = MEM_WAIT;
            wait_nxt  = wait_inc[TO_W-1:0];
          end
        end else begin
          state_nxt = RUN;
          wait_nxt  = {TO_W{1'b0}};
          // A redirect flushes the ID instruction, so its load-use hazard is moot
          if (redirect) begin
            pc_we       = 1'b1;
            ifid_we     = 1'b1;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            exmem_we    = 1'b1;
            flush_evt   = 1'b1;
          end else if (load_hazard) begin
            idex_bubble = 1'b1;
            exmem_we    = 1'b1;
          end else begin
            pc_we    = 1'b1;
            ifid_we  = 1'b1;
            exmem_we = 1'b1;
          end
        end
      end
      ERROR: begin
        ifid_flush   = 1'b1;
        idex_bubble  = 1'b1;
        memwb_bubble = 1'b1;
        state_nxt    = ERROR;
      end
      default: begin
        ifid_flush   = 1'b1;
        idex_bubble  = 1'b1;
        memwb_bubble = 1'b1;
        state_nxt    = START;
        wait_nxt     = {TO_W{1'b0}};
      end
    endcase
  end

  // State, wait timer, sticky timeout flag and saturating event counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= START;
      wait_cnt    <= {TO_W{1'b0}};
      mem_timeout <= 1'b0;
      stall_cnt   <= {CNT_W{1'b0}};
      flush_cnt   <= {CNT_W{1'b0}};
    end else begin
      state       <= state_nxt;
      wait_cnt    <= wait_nxt;
      mem_timeout <= mem_timeout | (state_nxt == ERROR);
      if ((state != START) && !pc_we && (stall_cnt != CNT_MAX)) begin
        stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (flush_evt && (flush_cnt != CNT_MAX)) begin
        flush_cnt <= flush_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Scoreboard bench: directed steps push hand-computed expectations, a negedge monitor
// pops and compares. DUT a uses default parameters, DUT b a small CNT_W/MEM_TO build.
module tb_pipeline_stall_ctrl;

  logic clk = 1'b0;
  logic rst_a = 1'b0;
  logic rst_b = 1'b0;
  logic load_hazard = 1'b0;
  logic redirect = 1'b0;
  logic mem_req = 1'b0;
  logic mem_ready = 1'b0;

  logic a_pc_we, a_ifid_we, a_ifid_flush, a_idex_bubble, a_exmem_we, a_memwb_bubble, a_tmo;
  logic [15:0] a_st, a_fl;
  logic b_pc_we, b_ifid_we, b_ifid_flush, b_idex_bubble, b_exmem_we, b_memwb_bubble, b_tmo;
  logic [3:0] b_st, b_fl;

  always #5 clk = ~clk;

  pipeline_stall_ctrl dut_a (
    .clk(clk), .rst_n(rst_a), .load_hazard(load_hazard), .redirect(redirect),
    .mem_req(mem_req), .mem_ready(mem_ready), .pc_we(a_pc_we), .ifid_we(a_ifid_we),
    .ifid_flush(a_ifid_flush), .idex_bubble(a_idex_bubble), .exmem_we(a_exmem_we),
    .memwb_bubble(a_memwb_bubble), .mem_timeout(a_tmo), .stall_cnt(a_st), .flush_cnt(a_fl)
  );

  pipeline_stall_ctrl #(.CNT_W(4), .TO_W(8), .MEM_TO(4)) dut_b (
    .clk(clk), .rst_n(rst_b), .load_hazard(load_hazard), .redirect(redirect),
    .mem_req(mem_req), .mem_ready(mem_ready), .pc_we(b_pc_we), .ifid_we(b_ifid_we),
    .ifid_flush(b_ifid_flush), .idex_bubble(b_idex_bubble), .exmem_we(b_exmem_we),
    .memwb_bubble(b_memwb_bubble), .mem_timeout(b_tmo), .stall_cnt(b_st), .flush_cnt(b_fl)
  );

  // {pc_we, ifid_we, ifid_flush, idex_bubble, exmem_we, memwb_bubble}
  localparam logic [5:0] C_ST = 6'b001101;
  localparam logic [5:0] C_FR = 6'b000001;
  localparam logic [5:0] C_RD = 6'b111110;
  localparam logic [5:0] C_HZ = 6'b000110;
  localparam logic [5:0] C_NM = 6'b110010;

  typedef struct {
    bit          sel;
    int          id;
    logic [38:0] vec;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int step_id = 0;
  bit done = 1'b0;

  task automatic step(input bit sel, input logic r, input logic lh, input logic rd,
                      input logic mq, input logic mr, input logic [5:0] c,
                      input logic t, input int st, input int fl);
    exp_t e;
    @(posedge clk);
    #1;
    if (sel) rst_b = r; else rst_a = r;
    load_hazard = lh;
    redirect    = rd;
    mem_req     = mq;
    mem_ready   = mr;
    e.sel = sel;
    e.id  = step_id;
    e.vec = {c, t, 16'(st), 16'(fl)};
    q.push_back(e);
    step_id++;
  endtask

  // Monitor: outputs are valid every cycle, compare mid-cycle against queued expectation
  initial begin
    exp_t e;
    logic [38:0] act;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        if (e.sel)
          act = {b_pc_we, b_ifid_we, b_ifid_flush, b_idex_bubble, b_exmem_we, b_memwb_bubble,
                 b_tmo, 12'd0, b_st, 12'd0, b_fl};
        else
          act = {a_pc_we, a_ifid_we, a_ifid_flush, a_idex_bubble, a_exmem_we, a_memwb_bubble,
                 a_tmo, a_st, a_fl};
        checks++;
        if (act !== e.vec) begin
          errors++;
          $display("FAIL step%0d dut%0s ctrl/tmo/stall/flush got %b/%b/%0d/%0d want %b/%b/%0d/%0d",
                   e.id, e.sel ? "b" : "a", act[38:33], act[32], act[31:16], act[15:0],
                   e.vec[38:33], e.vec[32], e.vec[31:16], e.vec[15:0]);
        end
      end
    end
  end

  initial begin
    // DUT a: reset, start-up, hazard, redirect+hazard, memory wait
    step(0, 0, 0, 0, 0, 0, C_ST, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, C_ST, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, C_NM, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, C_NM, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0, C_HZ, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, C_NM, 0, 1, 0);
    step(0, 1, 1, 1, 0, 0, C_RD, 0, 1, 0);
    step(0, 1, 0, 0, 0, 0, C_NM, 0, 1, 1);
    step(0, 1, 0, 0, 1, 0, C_FR, 0, 1, 1);
    step(0, 1, 0, 0, 1, 0, C_FR, 0, 2, 1);
    step(0, 1, 0, 0, 1, 0, C_FR, 0, 3, 1);
    step(0, 1, 0, 1, 1, 1, C_RD, 0, 4, 1);
    step(0, 1, 0, 0, 0, 0, C_NM, 0, 4, 2);
    // memory completes together with a load-use hazard
    step(0, 1, 0, 0, 1, 0, C_FR, 0, 4, 2);
    step(0, 1, 1, 0, 1, 1, C_HZ, 0, 5, 2);
    step(0, 1, 0, 0, 0, 0, C_NM, 0, 6, 2);
    step(0, 1, 0, 0, 1, 1, C_NM, 0, 6, 2);
    step(0, 1, 0, 0, 0, 0, C_NM, 0, 6, 2);
    // async reset in MEM_WAIT
    step(0, 1, 0, 0, 1, 0, C_FR, 0, 6, 2);
    step(0, 1, 0, 0, 1, 0, C_FR, 0, 7, 2);
    step(0, 0, 0, 0, 1, 0, C_ST, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, C_ST, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, C_NM, 0, 0, 0);
    // freeze outranks redirect
    step(0, 1, 0, 1, 1, 0, C_FR, 0, 0, 0);
    step(0, 1, 0, 0, 0, 1, C_NM, 0, 1, 0);
    step(0, 1, 0, 0, 0, 0, C_NM, 0, 1, 0);

    // DUT b: saturation and timeout
    step(1, 0, 0, 0, 0, 0, C_ST, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, C_ST, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, C_NM, 0, 0, 0);
    for (int k = 0; k < 20; k++)
      step(1, 1, 1, 0, 0, 0, C_HZ, 0, (k > 15) ? 15 : k, 0);
    step(1, 1, 0, 0, 0, 0, C_NM, 0, 15, 0);
    for (int k = 0; k < 4; k++)
      step(1, 1, 0, 0, 1, 0, C_FR, 0, 15, 0);
    step(1, 1, 0, 0, 1, 0, C_ST, 1, 15, 0);
    step(1, 1, 0, 1, 1, 1, C_ST, 1, 15, 0);
    step(1, 1, 1, 0, 0, 0, C_ST, 1, 15, 0);
    step(1, 0, 0, 0, 0, 0, C_ST, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, C_ST, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, C_NM, 0, 0, 0);

    for (int w = 0; w < 10 && q.size() > 0; w++) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain pending %0d want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
